// File: rtl/alu_wb_pkg.sv
// Shared types and helpers for the ALU result/writeback stage.
package alu_wb_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    MUL  = 4'd2,
    MULH = 4'd3,
    MULS = 4'd4,
    AND  = 4'd5,
    OR   = 4'd6,
    XOR  = 4'd7,
    SLL  = 4'd8,
    SRL  = 4'd9,
    SRA  = 4'd10,
    SEQ  = 4'd11,
    SLTU = 4'd12,
    SLTS = 4'd13,
    MUX  = 4'd14,
    ADDC = 4'd15
  } funct_t;

  localparam int DATA_W = 16;

  // Result payload; the destination address travels alongside it in the FIFO.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              cwen;
    logic              carry;
  } wb_entry_t;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEFAULT_DEPTH = 4;
  localparam int COUNT_W       = count_width(DEFAULT_DEPTH);

  function automatic logic [DATA_W-1:0] select_result(input funct_t f,
                                                      input logic [15:0] alu_out,
                                                      input logic [31:0] mul_out);
    case (f)
      MUL:     return mul_out[15:0];
      MULH:    return mul_out[31:16];
      default: return alu_out;
    endcase
  endfunction

endpackage

// File: rtl/alu_wb_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; pop-before-push
// so a simultaneous push and pop is accepted even when full.
module alu_wb_fifo
  import alu_wb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic [count_width(DEPTH)-1:0] count,
  output logic                          full,
  output logic                          empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is carried by count and
  // the pointers, so clearing it would only cost flops.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU result stage: aligns destination tags with ALU latency, buffers results
// and shares the register-file write port with the load unit (loads first).
// Optional macro ALU_WB_ERROR_CHECK_EN compiles in the sticky io_error logic.
module alu_writeback
  import alu_wb_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_issue_valid,
  input  logic [ADDR_W-1:0] io_issue_rd,
  input  logic [3:0]        io_issue_funct,
  input  logic              io_alu_valid,
  input  logic [15:0]       io_alu_out,
  input  logic [31:0]       io_alu_mul_out,
  input  logic              io_alu_carry_out,
  input  logic              io_lsu_wen,
  input  logic [ADDR_W-1:0] io_lsu_addr,
  input  logic [15:0]       io_lsu_data,
  output logic              io_rf_wen,
  output logic [ADDR_W-1:0] io_rf_addr,
  output logic [15:0]       io_rf_data,
  output logic              io_carry_wen,
  output logic [ADDR_W-1:0] io_carry_addr,
  output logic              io_carry_data,
  output logic              io_stall,
  output logic              io_error
);

  localparam int CNT_W       = count_width(DEPTH);
  localparam int IN_FLIGHT_W = $clog2(LATENCY + 1);
  localparam int CRED_W      = $clog2(LATENCY + DEPTH + 1);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    funct_t            funct;
  } tag_t;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    wb_entry_t         wb;
  } fifo_entry_t;

  tag_t              tag_pipe [LATENCY];
  tag_t              head;
  logic              pair;
  logic              bypass;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  fifo_entry_t       alu_entry;
  fifo_entry_t       fifo_head;
  fifo_entry_t       wr_sel;
  logic [IN_FLIGHT_W-1:0] in_flight;
  logic [CRED_W-1:0] credits;
  logic              stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{valid: io_issue_valid, rd: io_issue_rd, funct: funct_t'(io_issue_funct)};
      for (int i = 1; i < LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign head = tag_pipe[LATENCY-1];
  assign pair = io_alu_valid && head.valid;

  assign alu_entry.rd       = head.rd;
  assign alu_entry.wb.data  = select_result(head.funct, io_alu_out, io_alu_mul_out);
  assign alu_entry.wb.cwen  = (head.funct == ADDC);
  assign alu_entry.wb.carry = io_alu_carry_out;

  // An empty FIFO is skipped so a result reaches the port the cycle after it
  // arrives; this is equivalent to enqueue-and-pop in the same cycle.
  assign fifo_pop  = !io_lsu_wen && !fifo_empty;
  assign bypass    = !io_lsu_wen && fifo_empty && pair;
  assign fifo_push = pair && !bypass && (!fifo_full || fifo_pop);
  assign wr_sel    = fifo_pop ? fifo_head : alu_entry;

  alu_wb_fifo #(
    .WIDTH ($bits(fifo_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (alu_entry),
    .rdata (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // NOTE: every variable written in always_comb gets a default first so no
  // latch is inferred.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < LATENCY; i++) in_flight += IN_FLIGHT_W'(tag_pipe[i].valid);
  end

  // Stall when one more issue could exceed FIFO capacity (credits + 1 > DEPTH).
  assign credits  = CRED_W'(in_flight) + CRED_W'(fifo_count);
  assign stall    = (credits >= CRED_W'(DEPTH));
  assign io_stall = stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      io_rf_wen     <= 1'b0;
      io_rf_addr    <= '0;
      io_rf_data    <= '0;
      io_carry_wen  <= 1'b0;
      io_carry_addr <= '0;
      io_carry_data <= 1'b0;
    end else if (io_lsu_wen) begin
      io_rf_wen     <= 1'b1;
      io_rf_addr    <= io_lsu_addr;
      io_rf_data    <= io_lsu_data;
      io_carry_wen  <= 1'b0;
      io_carry_addr <= '0;
      io_carry_data <= 1'b0;
    end else if (fifo_pop || bypass) begin
      io_rf_wen     <= 1'b1;
      io_rf_addr    <= wr_sel.rd;
      io_rf_data    <= wr_sel.wb.data;
      io_carry_wen  <= wr_sel.wb.cwen;
      io_carry_addr <= wr_sel.rd;
      io_carry_data <= wr_sel.wb.carry;
    end else begin
      io_rf_wen     <= 1'b0;
      io_rf_addr    <= '0;
      io_rf_data    <= '0;
      io_carry_wen  <= 1'b0;
      io_carry_addr <= '0;
      io_carry_data <= 1'b0;
    end
  end

`ifdef ALU_WB_ERROR_CHECK_EN
  logic overflow;
  logic err_event;
  logic error_q;

  assign overflow  = pair && !bypass && fifo_full && !fifo_pop;
  assign err_event = (io_alu_valid != head.valid) || (io_issue_valid && stall) || overflow;

  always_ff @(posedge clock) begin
    if (reset)          error_q <= 1'b0;
    else if (err_event) error_q <= 1'b1;
  end

  assign io_error = error_q;
`else
  assign io_error = 1'b0;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback with a behavioural
// fixed-latency ALU model driving the io_alu_* inputs.
module tb_alu_writeback;
  import alu_wb_pkg::*;

  localparam int LATENCY = 3;
  localparam int DEPTH   = 4;
  localparam int ADDR_W  = 11;
`ifdef ALU_WB_ERROR_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset;
  logic              io_issue_valid;
  logic [ADDR_W-1:0] io_issue_rd;
  logic [3:0]        io_issue_funct;
  logic              io_alu_valid;
  logic [15:0]       io_alu_out;
  logic [31:0]       io_alu_mul_out;
  logic              io_alu_carry_out;
  logic              io_lsu_wen;
  logic [ADDR_W-1:0] io_lsu_addr;
  logic [15:0]       io_lsu_data;
  logic              io_rf_wen;
  logic [ADDR_W-1:0] io_rf_addr;
  logic [15:0]       io_rf_data;
  logic              io_carry_wen;
  logic [ADDR_W-1:0] io_carry_addr;
  logic              io_carry_data;
  logic              io_stall;
  logic              io_error;

  alu_writeback #(.LATENCY(LATENCY), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .io_issue_valid   (io_issue_valid),
    .io_issue_rd      (io_issue_rd),
    .io_issue_funct   (io_issue_funct),
    .io_alu_valid     (io_alu_valid),
    .io_alu_out       (io_alu_out),
    .io_alu_mul_out   (io_alu_mul_out),
    .io_alu_carry_out (io_alu_carry_out),
    .io_lsu_wen       (io_lsu_wen),
    .io_lsu_addr      (io_lsu_addr),
    .io_lsu_data      (io_lsu_data),
    .io_rf_wen        (io_rf_wen),
    .io_rf_addr       (io_rf_addr),
    .io_rf_data       (io_rf_data),
    .io_carry_wen     (io_carry_wen),
    .io_carry_addr    (io_carry_addr),
    .io_carry_data    (io_carry_data),
    .io_stall         (io_stall),
    .io_error         (io_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // ALU model: what the ALU will answer for the issue of this cycle.
  logic        resp_valid;
  logic [15:0] resp_out;
  logic [31:0] resp_mul;
  logic        resp_carry;
  logic        alu_pv [LATENCY];
  logic [15:0] alu_po [LATENCY];
  logic [31:0] alu_pm [LATENCY];
  logic        alu_pc [LATENCY];

  typedef struct {
    funct_t      funct;
    logic [10:0] rd;
    logic [15:0] alu_out;
    logic [31:0] mul_out;
    logic        carry;
    logic [15:0] exp_data;
    logic        exp_cwen;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock; inputs set before the call belong to the ending cycle.
  task automatic tick();
    logic r;
    r = reset;
    @(posedge clock);
    if (r) begin
      for (int i = 0; i < LATENCY; i++) begin
        alu_pv[i] = 1'b0; alu_po[i] = '0; alu_pm[i] = '0; alu_pc[i] = 1'b0;
      end
    end else begin
      for (int i = LATENCY - 1; i > 0; i--) begin
        alu_pv[i] = alu_pv[i-1]; alu_po[i] = alu_po[i-1];
        alu_pm[i] = alu_pm[i-1]; alu_pc[i] = alu_pc[i-1];
      end
      alu_pv[0] = resp_valid; alu_po[0] = resp_out;
      alu_pm[0] = resp_mul;   alu_pc[0] = resp_carry;
    end
    #1;
    io_alu_valid     = alu_pv[LATENCY-1];
    io_alu_out       = alu_po[LATENCY-1];
    io_alu_mul_out   = alu_pm[LATENCY-1];
    io_alu_carry_out = alu_pc[LATENCY-1];
  endtask

  task automatic set_issue(input funct_t f, input logic [10:0] rd, input logic [15:0] o,
                           input logic [31:0] m, input logic c, input logic respond);
    io_issue_valid = 1'b1; io_issue_rd = rd; io_issue_funct = f;
    resp_valid = respond; resp_out = o; resp_mul = m; resp_carry = c;
  endtask

  task automatic clear_issue();
    io_issue_valid = 1'b0; io_issue_rd = '0; io_issue_funct = '0;
    resp_valid = 1'b0; resp_out = '0; resp_mul = '0; resp_carry = 1'b0;
  endtask

  task automatic set_lsu(input logic en, input logic [10:0] a, input logic [15:0] d);
    io_lsu_wen = en; io_lsu_addr = a; io_lsu_data = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_issue();
    set_lsu(1'b0, '0, '0);
    tick();
    reset = 1'b0;
  endtask

  // Runs the load-priority sequence; extra=1 adds an issue during stall so a
  // push meets a full FIFO in the same cycle as a pop.
  task automatic run_lsu_sequence(input logic extra);
    int c;
    int n_alu;
    n_alu = extra ? 5 : 4;
    for (int k = 0; k < 16; k++) begin
      clear_issue();
      if (k < 4)             set_issue(ADD, 11'(k + 1), 16'hC000 + 16'(k + 1), 32'h0, 1'b0, 1'b1);
      if (extra && k == 6)   set_issue(ADD, 11'd5, 16'hC005, 32'h0, 1'b0, 1'b1);
      if (k >= 3 && k <= 8)  set_lsu(1'b1, 11'h100 + 11'(k - 3), 16'hA000 + 16'(k - 3));
      else                   set_lsu(1'b0, '0, '0);
      tick();
      c = k + 1;
      if (c >= 4 && c <= 9) begin
        check($sformatf("lsu_seq%0d c%0d load wen", extra, c), io_rf_wen, 1);
        check($sformatf("lsu_seq%0d c%0d load addr", extra, c), io_rf_addr, 11'h100 + 11'(c - 4));
        check($sformatf("lsu_seq%0d c%0d load data", extra, c), io_rf_data, 16'hA000 + 16'(c - 4));
      end else if (c >= 10 && c < 10 + n_alu) begin
        check($sformatf("lsu_seq%0d c%0d alu wen", extra, c), io_rf_wen, 1);
        check($sformatf("lsu_seq%0d c%0d alu addr", extra, c), io_rf_addr, 11'(c - 9));
        check($sformatf("lsu_seq%0d c%0d alu data", extra, c), io_rf_data, 16'hC000 + 16'(c - 9));
      end else begin
        check($sformatf("lsu_seq%0d c%0d idle wen", extra, c), io_rf_wen, 0);
      end
      check($sformatf("lsu_seq%0d c%0d carry_wen", extra, c), io_carry_wen, 0);
      check($sformatf("lsu_seq%0d c%0d stall", extra, c), io_stall,
            (c >= 4 && c <= (extra ? 10 : 9)) ? 1 : 0);
    end
    clear_issue();
    set_lsu(1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    clear_issue();
    set_lsu(1'b0, '0, '0);
    io_alu_valid = 1'b0; io_alu_out = '0; io_alu_mul_out = '0; io_alu_carry_out = 1'b0;
    for (int i = 0; i < LATENCY; i++) begin
      alu_pv[i] = 1'b0; alu_po[i] = '0; alu_pm[i] = '0; alu_pc[i] = 1'b0;
    end
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check("reset rf_wen", io_rf_wen, 0);
    check("reset rf_addr", io_rf_addr, 0);
    check("reset rf_data", io_rf_data, 0);
    check("reset carry_wen", io_carry_wen, 0);
    check("reset stall", io_stall, 0);
    check("reset error", io_error, 0);

    // Single-op vectors: result appears exactly LATENCY+1 cycles after issue
    vecs[0] = '{MULH, 11'd5,     16'hAAAA, 32'h1234_5678, 1'b0, 16'h1234, 1'b0};
    vecs[1] = '{MUL,  11'd5,     16'hAAAA, 32'h1234_5678, 1'b0, 16'h5678, 1'b0};
    vecs[2] = '{ADDC, 11'd9,     16'h0001, 32'h0,         1'b1, 16'h0001, 1'b1};
    vecs[3] = '{ADD,  11'd9,     16'h0001, 32'h0,         1'b1, 16'h0001, 1'b0};
    vecs[4] = '{MULS, 11'h7FF,   16'h4321, 32'hFFFF_0000, 1'b0, 16'h4321, 1'b0};
    vecs[5] = '{ADDC, 11'd0,     16'hFFFF, 32'h0,         1'b0, 16'hFFFF, 1'b1};
    vecs[6] = '{SLTS, 11'h400,   16'h0001, 32'hDEAD_BEEF, 1'b1, 16'h0001, 1'b0};
    for (int v = 0; v < 7; v++) begin
      set_issue(vecs[v].funct, vecs[v].rd, vecs[v].alu_out, vecs[v].mul_out, vecs[v].carry, 1'b1);
      tick();
      clear_issue();
      for (int j = 0; j < LATENCY - 1; j++) tick();
      check($sformatf("vec%0d early wen", v), io_rf_wen, 0);
      tick();
      check($sformatf("vec%0d rf_wen", v), io_rf_wen, 1);
      check($sformatf("vec%0d rf_addr", v), io_rf_addr, vecs[v].rd);
      check($sformatf("vec%0d rf_data", v), io_rf_data, vecs[v].exp_data);
      check($sformatf("vec%0d carry_wen", v), io_carry_wen, vecs[v].exp_cwen);
      if (vecs[v].exp_cwen) begin
        check($sformatf("vec%0d carry_addr", v), io_carry_addr, vecs[v].rd);
        check($sformatf("vec%0d carry_data", v), io_carry_data, vecs[v].carry);
      end
      tick();
      check($sformatf("vec%0d after wen", v), io_rf_wen, 0);
    end
    check("vectors error", io_error, 0);

    // Back-to-back issues drain at one result per cycle
    for (int k = 0; k < 3; k++) begin
      set_issue(SUB, 11'(20 + k), 16'h0100 + 16'(k), 32'h0, 1'b0, 1'b1);
      tick();
    end
    clear_issue();
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b2b%0d wen", k), io_rf_wen, 1);
      check($sformatf("b2b%0d addr", k), io_rf_addr, 11'(20 + k));
      check($sformatf("b2b%0d data", k), io_rf_data, 16'h0100 + 16'(k));
      tick();
    end
    check("b2b drained", io_rf_wen, 0);

    // Single load write appears the next cycle
    set_lsu(1'b1, 11'h3AB, 16'h5A5A);
    tick();
    set_lsu(1'b0, '0, '0);
    check("load wen", io_rf_wen, 1);
    check("load addr", io_rf_addr, 11'h3AB);
    check("load data", io_rf_data, 16'h5A5A);
    check("load carry_wen", io_carry_wen, 0);

    // Load priority with four returning ADDs; no drops, no error
    do_reset();
    run_lsu_sequence(1'b0);
    check("lsu priority error", io_error, 0);

    // Full FIFO push+pop in one cycle (issue forced during stall)
    do_reset();
    run_lsu_sequence(1'b1);
    check("full pushpop error", io_error, EXP_ERR);

    // Unmatched ALU valid sets sticky error
    do_reset();
    check("err pre", io_error, 0);
    io_alu_valid = 1'b1;
    io_alu_out   = 16'hFACE;
    tick();
    check("err alu_valid no tag", io_error, EXP_ERR);
    check("err no write", io_rf_wen, 0);
    for (int k = 0; k < 3; k++) tick();
    check("err sticky", io_error, EXP_ERR);
    do_reset();
    check("err cleared", io_error, 0);

    // Tag with no ALU response is discarded and flagged
    set_issue(ADD, 11'd7, 16'h7777, 32'h0, 1'b0, 1'b0);
    tick();
    clear_issue();
    for (int k = 0; k < LATENCY; k++) tick();
    check("missing result no write", io_rf_wen, 0);
    check("missing result error", io_error, EXP_ERR);

    // Reset mid-operation: 3 FIFO entries and 2 tags in flight
    do_reset();
    for (int k = 0; k < 6; k++) begin
      clear_issue();
      if (k != 3) set_issue(ADD, 11'(40 + k), 16'h0E00 + 16'(k), 32'h0, 1'b1, 1'b1);
      set_lsu(1'b1, 11'h200 + 11'(k), 16'(k));
      tick();
    end
    clear_issue();
    set_lsu(1'b0, '0, '0);
    check("midreset stall before", io_stall, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset rf_wen", io_rf_wen, 0);
    check("midreset rf_addr", io_rf_addr, 0);
    check("midreset rf_data", io_rf_data, 0);
    check("midreset carry_wen", io_carry_wen, 0);
    check("midreset carry_addr", io_carry_addr, 0);
    check("midreset carry_data", io_carry_data, 0);
    check("midreset stall", io_stall, 0);
    check("midreset error", io_error, 0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check($sformatf("postreset%0d rf_wen", k), io_rf_wen, 0);
      check($sformatf("postreset%0d carry_wen", k), io_carry_wen, 0);
    end
    check("postreset error", io_error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
